// File: rtl/alu_pkg.sv
// Shared ALU types: operation modes and the arbiter state encoding.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SRA = 3'd7
    } alu_mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/alu_share_arb_alu32.sv
// ALU32: purely combinational 32-bit ALU; shift amount is B[4:0].
module ALU32
    import alu_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  alu_mode_t   mode,
    output logic [31:0] X
);

    logic [4:0] shamt;
    assign shamt = B[4:0];

    // Select the operation result for the requested mode.
    always_comb begin
        X = '0;
        case (mode)
            ALU_ADD: X = A + B;
            ALU_SUB: X = A - B;
            ALU_AND: X = A & B;
            ALU_OR:  X = A | B;
            ALU_XOR: X = A ^ B;
            ALU_SLL: X = A << shamt;
            ALU_SRL: X = A >> shamt;
            ALU_SRA: X = $unsigned($signed(A) >>> shamt);
            default: X = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: one ALU32 shared by N_REQ requesters through a round-robin
// arbiter; the result is registered and returned with per-requester backpressure.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    input  logic [3*N_REQ-1:0]   req_mode,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [31:0]          rsp_x,
    output logic                 busy
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    typedef logic [IDX_W-1:0] idx_t;

    // First valid requester at or after prio, wrapping; returns {found, index}.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                               input idx_t             prio);
        logic        found;
        idx_t        idx;
        idx_t        cand_i;
        int unsigned cand;
        found = 1'b0;
        idx   = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = 32'(prio) + off;
            if (cand >= N_REQ) cand = cand - N_REQ;
            cand_i = idx_t'(cand);
            if (!found && valid[cand_i]) begin
                found = 1'b1;
                idx   = cand_i;
            end
        end
        return {found, idx};
    endfunction

    // Successor index modulo N_REQ.
    function automatic idx_t next_idx(input idx_t i);
        int unsigned n;
        n = 32'(i) + 1;
        if (n >= N_REQ) n = 0;
        return idx_t'(n);
    endfunction

    arb_state_t  state_q, state_d;
    idx_t        prio_q,  prio_d;
    idx_t        owner_q, owner_d;
    logic [31:0] rsp_x_q, rsp_x_d;

    logic        pick_found;
    idx_t        pick_idx;
    logic        can_accept;
    logic        grant;
    logic [31:0] alu_a, alu_b, alu_x;
    alu_mode_t   alu_mode;

    assign {pick_found, pick_idx} = rr_pick(req_valid, prio_q);
    // A new operation fits when the result register is empty or being drained now.
    assign can_accept = (state_q == ST_IDLE) || rsp_ready[owner_q];
    assign grant      = can_accept && pick_found;

    // Operand mux from the selected requester into the shared ALU.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_mode = ALU_ADD;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_idx == idx_t'(i)) begin
                alu_a    = req_a[32*i +: 32];
                alu_b    = req_b[32*i +: 32];
                alu_mode = alu_mode_t'(req_mode[3*i +: 3]);
            end
        end
    end

    ALU32 u_alu (
        .A    (alu_a),
        .B    (alu_b),
        .mode (alu_mode),
        .X    (alu_x)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Result, owner and priority registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q  <= '0;
            owner_q <= '0;
            rsp_x_q <= '0;
        end else begin
            prio_q  <= prio_d;
            owner_q <= owner_d;
            rsp_x_q <= rsp_x_d;
        end
    end

    // Next state: a grant always (re)fills the result register; a drain without a grant empties it.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        rsp_x_d = rsp_x_q;
        if (grant) begin
            state_d = ST_HOLD;
            prio_d  = next_idx(pick_idx);
            owner_d = pick_idx;
            rsp_x_d = alu_x;
        end else if (state_q == ST_HOLD && rsp_ready[owner_q]) begin
            state_d = ST_IDLE;
        end
    end

    // Handshake outputs; req_ready is masked while reset is asserted.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_ready[i] = rst_n && grant && (pick_idx == idx_t'(i));
            rsp_valid[i] = (state_q == ST_HOLD) && (owner_q == idx_t'(i));
        end
    end

    assign busy  = (state_q == ST_HOLD);
    assign rsp_x = rsp_x_q;

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Shares a single ALU32 instance between N_REQ requesters, e.g. the execute stage and the address-generation unit, so the core needs only one 32-bit ALU. Each requester submits an operand pair and a 3-bit mode over a valid/ready channel. A round-robin arbiter grants one request per cycle. The registered result is returned on a per-requester response channel with backpressure.

## Interface
Parameters:
- N_REQ, 2, number of requesters; supported range 2..4.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- req_valid, input, N_REQ: requester i has an operation pending.
- req_ready, output, N_REQ: request i is accepted this cycle; one-hot or zero.
- req_a, input, 32*N_REQ: operand A; requester i uses bits [32i+31:32i].
- req_b, input, 32*N_REQ: operand B, packed the same way.
- req_mode, input, 3*N_REQ: ALU mode; requester i uses bits [3i+2:3i].
- rsp_valid, output, N_REQ: result available for requester i; one-hot or zero.
- rsp_ready, input, N_REQ: requester i consumes its result.
- rsp_x, output, 32: result value, meaningful while any rsp_valid bit is high.
- busy, output, 1: result register occupied (state HOLD).

## Operation
- Mode encoding:
  - 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA; shift amount is B[4:0].
- ADD and SUB wrap modulo 2^32. No carry or overflow output.
- The ALU is combinational and is fed from the granted requester's operands through a mux. Its output is captured into the rsp_x register.
- State IDLE:
  - If any req_valid is set, grant exactly one requester by round-robin: req_ready[g]=1.
  - Capture ALU(A_g, B_g, mode_g) into rsp_x, store owner=g, go to HOLD.
  - If no req_valid is set, stay in IDLE.
- State HOLD:
  - rsp_valid[owner]=1.
  - If rsp_ready[owner]=0: hold rsp_x and owner, req_ready=0.
  - If rsp_ready[owner]=1 and some req_valid is set: grant and capture in the same cycle, stay in HOLD. Throughput is one operation per cycle.
  - If rsp_ready[owner]=1 and no req_valid is set: go to IDLE.
- Round-robin:
  - Pointer prio holds the highest-priority index.
  - After a grant to g, prio becomes (g+1) mod N_REQ.
  - The search starts at prio and wraps around.
- req_ready is combinational from state, rsp_ready[owner], req_valid and prio. It never depends on req_a, req_b or req_mode.
- Requesters hold valid and operands stable until accepted. Dropping valid early is allowed; the request is simply not served.
- rsp_ready bits of non-owners are ignored.

## Timing
- Reset values: rsp_valid=0, rsp_x=0, busy=0, req_ready=0, state=IDLE, prio=0, owner=0.
- Latency: request accepted at edge k; rsp_valid[g] and rsp_x are valid after edge k, in cycle k+1.
- Back-to-back: rsp_ready and req_ready may both be high in one cycle. The new result replaces the old at the same edge with no bubble.
- A requester that is both owner and requesting is served normally. It sees its new result in the next cycle.
- Simultaneous requests from all ports: each is served within N_REQ consecutive grants. There is no starvation.
- Reset asserted mid-operation: the pending result is discarded and all outputs return to reset values immediately (asynchronous). There is no stale rsp_valid after rst_n rises.
- Unused rsp_valid bits are 0 at all times.

## Structure
- Shared package alu_pkg holds:
  - the alu_mode_t 3-bit enum: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA;
  - the state enum: ST_IDLE, ST_HOLD.
- One sub-module: the existing ALU32 (A, B, mode, X), instantiated once.
- The round-robin grant function stays inside alu_share_arb.

## Test plan
- Single request: port 0 sends A=1, B=2, mode 0 → next cycle rsp_valid=01, rsp_x=3; rsp_ready=1 → IDLE, busy=0.
- Contention with N_REQ=2, both ports valid continuously:
  - port 0: A=0xCC, B=0xCA, mode 2;
  - port 1: A=0xCC, B=2, mode 5.
  - Required response: grants alternate 0,1,0,1; results alternate 0xC8 and 0x330; rsp_ready held high, so one result per cycle.
- Backpressure: port 1 sends A=0x0A, B=0x20, mode 1 and holds rsp_ready=0 for 3 cycles → rsp_x stays 0xFFFFFFEA, req_ready stays 0 for port 0; port 0 is granted in the cycle rsp_ready[1] rises.
- Arithmetic shift: A=0x80000000, B=4, mode 7 → 0xF8000000. Same operands, mode 6 → 0x08000000.
- Reset mid-HOLD: drive rst_n low while rsp_valid=01 → rsp_valid=0 and rsp_x=0 immediately. After release, prio=0, and port 0 wins a simultaneous request.
